// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory request/response port between fetch and data stages
//
// Purpose:
//   Arbitrates the fetch-stage instruction requester and the mem-stage data
//   requester onto one memory port. Data wins by default. A starvation counter
//   forces an instruction grant after STARVE_LIMIT consecutive data grants
//   while fetch is waiting. Every accepted request pushes its source ID into an
//   in-order grant FIFO, and the FIFO head steers each response back to the
//   requester that issued it.
//
// Parameters:
//   MAX_OUTSTANDING  grant FIFO depth and in-flight limit (power of 2, >= 1)
//   STARVE_LIMIT     data grants allowed while fetch waits (>= 1)
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   instr_req_* / instr_rsp_*          instruction requester (word reads only)
//   data_req_*  / data_rsp_*           data requester (reads and writes)
//   mem_req_*   / mem_rsp_*            shared port toward the memory wrapper
//   outstanding_o, busy_o              registered in-flight count and non-zero flag

module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,

  input  logic                              instr_req_valid_i,
  output logic                              instr_req_ready_o,
  input  logic [31:0]                       instr_req_addr_i,
  output logic                              instr_rsp_valid_o,
  input  logic                              instr_rsp_ready_i,
  output logic [31:0]                       instr_rsp_data_o,
  output logic                              instr_rsp_error_o,

  input  logic                              data_req_valid_i,
  output logic                              data_req_ready_o,
  input  logic [31:0]                       data_req_addr_i,
  input  logic                              data_req_write_i,
  input  logic [2:0]                        data_req_size_i,
  input  logic [31:0]                       data_req_data_i,
  input  logic [3:0]                        data_req_strb_i,
  output logic                              data_rsp_valid_o,
  input  logic                              data_rsp_ready_i,
  output logic [31:0]                       data_rsp_data_o,
  output logic                              data_rsp_error_o,

  output logic                              mem_req_valid_o,
  input  logic                              mem_req_ready_i,
  output logic [31:0]                       mem_req_addr_o,
  output logic                              mem_req_write_o,
  output logic [2:0]                        mem_req_size_o,
  output logic [31:0]                       mem_req_data_o,
  output logic [3:0]                        mem_req_strb_o,
  input  logic                              mem_rsp_valid_i,
  output logic                              mem_rsp_ready_o,
  input  logic [31:0]                       mem_rsp_data_i,
  input  logic                              mem_rsp_error_i,

  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
  output logic                              busy_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  // A depth-1 FIFO still needs a 1-bit pointer; it simply never moves.
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] FULL_CNT   = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR   = PW'(MAX_OUTSTANDING - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    LOCK_IDLE  = 2'd0,
    LOCK_INSTR = 2'd1,
    LOCK_DATA  = 2'd2
  } lock_state_e;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_INSTR = 2'd1,
    GNT_DATA  = 2'd2
  } gnt_e;

  lock_state_e                r_lock_state;
  logic [SW-1:0]              r_starve_cnt;
  logic [CW-1:0]              r_count;
  logic [PW-1:0]              r_wr_ptr;
  logic [PW-1:0]              r_rd_ptr;
  logic [MAX_OUTSTANDING-1:0] r_src_fifo;
  logic                       r_busy;

  gnt_e                       w_gnt;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_req_fire;
  logic                       w_instr_fire;
  logic                       w_data_fire;
  logic                       w_rsp_fire;
  logic                       w_head_is_data;
  logic [CW-1:0]              w_count_next;

  assign w_full         = (r_count == FULL_CNT);
  assign w_empty        = (r_count == '0);
  assign w_head_is_data = r_src_fifo[r_rd_ptr];

  // Grant selection looks only at registered state (count, lock, starve) and
  // the request valids, so no response input can reach the request side.
  // rst_ni gates the grant so request outputs drop to zero the moment reset
  // asserts, even if an upstream stage is still presenting a request.
  always_comb begin
    w_gnt = GNT_NONE;
    if (r_lock_state == LOCK_DATA) begin
      w_gnt = GNT_DATA;
    end else if (r_lock_state == LOCK_INSTR) begin
      w_gnt = GNT_INSTR;
    end else if (!w_full) begin
      if (data_req_valid_i && instr_req_valid_i) begin
        w_gnt = (r_starve_cnt == STARVE_MAX) ? GNT_INSTR : GNT_DATA;
      end else if (data_req_valid_i) begin
        w_gnt = GNT_DATA;
      end else if (instr_req_valid_i) begin
        w_gnt = GNT_INSTR;
      end
    end
    if (!rst_ni) begin
      w_gnt = GNT_NONE;
    end
  end

  // Request mux. Fetches are always full-word reads.
  always_comb begin
    mem_req_valid_o   = 1'b0;
    mem_req_addr_o    = '0;
    mem_req_write_o   = 1'b0;
    mem_req_size_o    = '0;
    mem_req_data_o    = '0;
    mem_req_strb_o    = '0;
    instr_req_ready_o = 1'b0;
    data_req_ready_o  = 1'b0;
    case (w_gnt)
      GNT_INSTR: begin
        mem_req_valid_o   = instr_req_valid_i;
        mem_req_addr_o    = instr_req_addr_i;
        mem_req_size_o    = 3'b010;
        mem_req_strb_o    = 4'hF;
        instr_req_ready_o = mem_req_ready_i;
      end
      GNT_DATA: begin
        mem_req_valid_o  = data_req_valid_i;
        mem_req_addr_o   = data_req_addr_i;
        mem_req_write_o  = data_req_write_i;
        mem_req_size_o   = data_req_size_i;
        mem_req_data_o   = data_req_data_i;
        mem_req_strb_o   = data_req_strb_i;
        data_req_ready_o = mem_req_ready_i;
      end
      default: begin
      end
    endcase
  end

  assign w_req_fire   = mem_req_valid_o && mem_req_ready_i;
  assign w_instr_fire = w_req_fire && (w_gnt == GNT_INSTR);
  assign w_data_fire  = w_req_fire && (w_gnt == GNT_DATA);

  // Response routing by FIFO head. With nothing in flight the response port
  // is not ready, so a spurious response is left on the bus untouched.
  always_comb begin
    instr_rsp_valid_o = 1'b0;
    instr_rsp_data_o  = '0;
    instr_rsp_error_o = 1'b0;
    data_rsp_valid_o  = 1'b0;
    data_rsp_data_o   = '0;
    data_rsp_error_o  = 1'b0;
    mem_rsp_ready_o   = 1'b0;
    if (!w_empty) begin
      if (w_head_is_data) begin
        data_rsp_valid_o = mem_rsp_valid_i;
        data_rsp_data_o  = mem_rsp_data_i;
        data_rsp_error_o = mem_rsp_error_i;
        mem_rsp_ready_o  = data_rsp_ready_i;
      end else begin
        instr_rsp_valid_o = mem_rsp_valid_i;
        instr_rsp_data_o  = mem_rsp_data_i;
        instr_rsp_error_o = mem_rsp_error_i;
        mem_rsp_ready_o   = instr_rsp_ready_i;
      end
    end
  end

  assign w_rsp_fire   = mem_rsp_valid_i && mem_rsp_ready_o;
  assign w_count_next = r_count + CW'(w_req_fire) - CW'(w_rsp_fire);

  // Grant lock: a presented but unaccepted request keeps its grant so the
  // mem_req_* fields cannot switch to the other requester mid-handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock_state <= LOCK_IDLE;
    end else begin
      case (r_lock_state)
        LOCK_IDLE: begin
          if (mem_req_valid_o && !mem_req_ready_i) begin
            r_lock_state <= (w_gnt == GNT_DATA) ? LOCK_DATA : LOCK_INSTR;
          end
        end
        LOCK_INSTR, LOCK_DATA: begin
          if (w_req_fire) begin
            r_lock_state <= LOCK_IDLE;
          end
        end
        default: r_lock_state <= LOCK_IDLE;
      endcase
    end
  end

  // Counts data grants taken while fetch is waiting; saturates at the limit,
  // which is what hands the next contested grant to fetch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_starve_cnt <= '0;
    end else if (!instr_req_valid_i || w_instr_fire) begin
      r_starve_cnt <= '0;
    end else if (w_data_fire && (r_starve_cnt != STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end

  // Grant-order FIFO: one source bit per in-flight transaction (1 = data).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_src_fifo <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_busy     <= 1'b0;
    end else begin
      if (w_req_fire) begin
        r_src_fifo[r_wr_ptr] <= (w_gnt == GNT_DATA);
        r_wr_ptr             <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_rsp_fire) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
      end
      r_count <= w_count_next;
      r_busy  <= (w_count_next != '0);
    end
  end

  assign outstanding_o = r_count;
  assign busy_o        = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter

module tb_mem_port_arbiter;

  localparam int MAX = 2;
  localparam int LIM = 4;

  logic        clk_i;
  logic        rst_ni;
  logic        instr_req_valid_i;
  logic        instr_req_ready_o;
  logic [31:0] instr_req_addr_i;
  logic        instr_rsp_valid_o;
  logic        instr_rsp_ready_i;
  logic [31:0] instr_rsp_data_o;
  logic        instr_rsp_error_o;
  logic        data_req_valid_i;
  logic        data_req_ready_o;
  logic [31:0] data_req_addr_i;
  logic        data_req_write_i;
  logic [2:0]  data_req_size_i;
  logic [31:0] data_req_data_i;
  logic [3:0]  data_req_strb_i;
  logic        data_rsp_valid_o;
  logic        data_rsp_ready_i;
  logic [31:0] data_rsp_data_o;
  logic        data_rsp_error_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_req_addr_o;
  logic        mem_req_write_o;
  logic [2:0]  mem_req_size_o;
  logic [31:0] mem_req_data_o;
  logic [3:0]  mem_req_strb_o;
  logic        mem_rsp_valid_i;
  logic        mem_rsp_ready_o;
  logic [31:0] mem_rsp_data_i;
  logic        mem_rsp_error_i;
  logic [1:0]  outstanding_o;
  logic        busy_o;

  mem_port_arbiter #(
    .MAX_OUTSTANDING(MAX),
    .STARVE_LIMIT   (LIM)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .instr_req_valid_i(instr_req_valid_i),
    .instr_req_ready_o(instr_req_ready_o),
    .instr_req_addr_i (instr_req_addr_i),
    .instr_rsp_valid_o(instr_rsp_valid_o),
    .instr_rsp_ready_i(instr_rsp_ready_i),
    .instr_rsp_data_o (instr_rsp_data_o),
    .instr_rsp_error_o(instr_rsp_error_o),
    .data_req_valid_i (data_req_valid_i),
    .data_req_ready_o (data_req_ready_o),
    .data_req_addr_i  (data_req_addr_i),
    .data_req_write_i (data_req_write_i),
    .data_req_size_i  (data_req_size_i),
    .data_req_data_i  (data_req_data_i),
    .data_req_strb_i  (data_req_strb_i),
    .data_rsp_valid_o (data_rsp_valid_o),
    .data_rsp_ready_i (data_rsp_ready_i),
    .data_rsp_data_o  (data_rsp_data_o),
    .data_rsp_error_o (data_rsp_error_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_req_write_o  (mem_req_write_o),
    .mem_req_size_o   (mem_req_size_o),
    .mem_req_data_o   (mem_req_data_o),
    .mem_req_strb_o   (mem_req_strb_o),
    .mem_rsp_valid_i  (mem_rsp_valid_i),
    .mem_rsp_ready_o  (mem_rsp_ready_o),
    .mem_rsp_data_i   (mem_rsp_data_i),
    .mem_rsp_error_i  (mem_rsp_error_i),
    .outstanding_o    (outstanding_o),
    .busy_o           (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    instr_req_valid_i = 1'b0; instr_req_addr_i = '0; instr_rsp_ready_i = 1'b0;
    data_req_valid_i  = 1'b0; data_req_addr_i  = '0; data_req_write_i  = 1'b0;
    data_req_size_i   = '0;   data_req_data_i  = '0; data_req_strb_i   = '0;
    data_rsp_ready_i  = 1'b0; mem_req_ready_i  = 1'b0;
    mem_rsp_valid_i   = 1'b0; mem_rsp_data_i   = '0; mem_rsp_error_i   = 1'b0;
  endtask

  task automatic drain(input string tag);
    instr_req_valid_i = 1'b0; data_req_valid_i = 1'b0;
    mem_rsp_valid_i = 1'b1; instr_rsp_ready_i = 1'b1; data_rsp_ready_i = 1'b1;
    for (int k = 0; k < 8 && outstanding_o != 0; k++) cyc();
    mem_rsp_valid_i = 1'b0;
    #2;
    chk({tag, "_drained"}, outstanding_o, 0);
  endtask

  // Single fetch: accepted at once, response three cycles later.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] rdata, input string tag);
    instr_req_valid_i = 1'b1; instr_req_addr_i = addr; mem_req_ready_i = 1'b1;
    #2;
    chk({tag, "_req_valid"}, mem_req_valid_o, 1);
    chk({tag, "_req_addr"}, mem_req_addr_o, addr);
    chk({tag, "_req_size"}, mem_req_size_o, 2);
    chk({tag, "_req_strb"}, mem_req_strb_o, 4'hF);
    chk({tag, "_req_write"}, mem_req_write_o, 0);
    chk({tag, "_instr_ready"}, instr_req_ready_o, 1);
    chk({tag, "_data_ready"}, data_req_ready_o, 0);
    chk({tag, "_outst0"}, outstanding_o, 0);
    cyc();
    instr_req_valid_i = 1'b0;
    #2;
    chk({tag, "_outst1"}, outstanding_o, 1);
    chk({tag, "_busy1"}, busy_o, 1);
    cyc(); cyc();
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = rdata; instr_rsp_ready_i = 1'b1;
    #2;
    chk({tag, "_rsp_valid"}, instr_rsp_valid_o, 1);
    chk({tag, "_rsp_data"}, instr_rsp_data_o, rdata);
    chk({tag, "_mem_rsp_ready"}, mem_rsp_ready_o, 1);
    chk({tag, "_data_rsp_valid"}, data_rsp_valid_o, 0);
    cyc();
    mem_rsp_valid_i = 1'b0;
    #2;
    chk({tag, "_outst_end"}, outstanding_o, 0);
    chk({tag, "_busy_end"}, busy_o, 0);
  endtask

  // Random-phase requester state and reference model.
  bit          i_pend, d_pend, d_write, i_rdy, d_rdy, m_rdy, r_vld, r_err;
  logic [31:0] i_addr, d_addr, d_data, r_data;
  logic [2:0]  d_size;
  logic [3:0]  d_strb;
  int          m_q[$];
  int          m_lock;
  int          m_starve;
  int          g, dst;
  bit          req_fire, rsp_fire, exp_rsp_rdy;
  string       seq;
  byte         got;
  int          run, max_run;

  initial begin
    idle();
    rst_ni = 1'b0;

    // Reset with requests and a response presented: everything stays quiet.
    instr_req_valid_i = 1'b1; instr_req_addr_i = 32'h44; mem_req_ready_i = 1'b1;
    mem_rsp_valid_i = 1'b1; instr_rsp_ready_i = 1'b1;
    #2;
    chk("rst_mem_req_valid", mem_req_valid_o, 0);
    chk("rst_instr_ready", instr_req_ready_o, 0);
    chk("rst_mem_req_addr", mem_req_addr_o, 0);
    chk("rst_mem_rsp_ready", mem_rsp_ready_o, 0);
    chk("rst_instr_rsp_valid", instr_rsp_valid_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_busy", busy_o, 0);
    idle();
    cyc(); cyc();
    rst_ni = 1'b1;
    cyc();

    do_fetch(32'h100, 32'h0000_0013, "fetch");

    // Both requesters held; data wins until fetch has waited LIM grants.
    seq = "DDDDIDDDDI";
    run = 0; max_run = 0;
    instr_req_valid_i = 1'b1; instr_req_addr_i = 32'h200;
    data_req_valid_i = 1'b1; data_req_addr_i = 32'h1000; data_req_size_i = 3'b010;
    data_req_strb_i = 4'hF; mem_req_ready_i = 1'b1;
    mem_rsp_valid_i = 1'b1; instr_rsp_ready_i = 1'b1; data_rsp_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #2;
      got = data_req_ready_o ? "D" : (instr_req_ready_o ? "I" : "-");
      chk($sformatf("starve_grant%0d", k), got, seq[k]);
      if (got == "D") run++;
      else run = 0;
      if (run > max_run) max_run = run;
      cyc();
    end
    chk("starve_max_wait_ok", (max_run <= LIM), 1);
    drain("starve");

    // Store stalled by memory; a fetch arriving meanwhile must not steal the port.
    idle();
    data_req_valid_i = 1'b1; data_req_addr_i = 32'h2000; data_req_write_i = 1'b1;
    data_req_size_i = 3'b010; data_req_data_i = 32'hDEAD_BEEF; data_req_strb_i = 4'hF;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        instr_req_valid_i = 1'b1; instr_req_addr_i = 32'h300;
      end
      #2;
      chk($sformatf("lock_valid%0d", k), mem_req_valid_o, 1);
      chk($sformatf("lock_addr%0d", k), mem_req_addr_o, 32'h2000);
      chk($sformatf("lock_write%0d", k), mem_req_write_o, 1);
      chk($sformatf("lock_wdata%0d", k), mem_req_data_o, 32'hDEAD_BEEF);
      chk($sformatf("lock_instr_ready%0d", k), instr_req_ready_o, 0);
      chk($sformatf("lock_data_ready%0d", k), data_req_ready_o, 0);
      cyc();
    end
    mem_req_ready_i = 1'b1;
    #2;
    chk("lock_accept_data_ready", data_req_ready_o, 1);
    chk("lock_accept_instr_ready", instr_req_ready_o, 0);
    chk("lock_accept_addr", mem_req_addr_o, 32'h2000);
    cyc();
    data_req_valid_i = 1'b0;
    #2;
    chk("lock_then_instr_ready", instr_req_ready_o, 1);
    chk("lock_then_instr_addr", mem_req_addr_o, 32'h300);
    chk("lock_then_instr_write", mem_req_write_o, 0);
    chk("lock_outst", outstanding_o, 1);
    cyc();
    drain("lock");

    // Fill the FIFO, stall the third request, then drain in order.
    idle();
    mem_req_ready_i = 1'b1;
    instr_req_valid_i = 1'b1; instr_req_addr_i = 32'h400;
    #2;
    chk("full_i_ready", instr_req_ready_o, 1);
    cyc();
    instr_req_valid_i = 1'b0;
    data_req_valid_i = 1'b1; data_req_addr_i = 32'h500;
    #2;
    chk("full_d_ready", data_req_ready_o, 1);
    cyc();
    data_req_valid_i = 1'b0;
    instr_req_valid_i = 1'b1; instr_req_addr_i = 32'h600;
    #2;
    chk("full_outst", outstanding_o, 2);
    chk("full_stall_valid", mem_req_valid_o, 0);
    chk("full_stall_ready", instr_req_ready_o, 0);
    cyc();
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'hAAAA;
    instr_rsp_ready_i = 1'b1; data_rsp_ready_i = 1'b1;
    #2;
    chk("full_rsp1_instr_valid", instr_rsp_valid_o, 1);
    chk("full_rsp1_instr_data", instr_rsp_data_o, 32'hAAAA);
    chk("full_rsp1_data_valid", data_rsp_valid_o, 0);
    chk("full_pop_cycle_valid", mem_req_valid_o, 0);
    cyc();
    mem_rsp_data_i = 32'hBBBB;
    #2;
    chk("full_rsp2_data_valid", data_rsp_valid_o, 1);
    chk("full_rsp2_data_data", data_rsp_data_o, 32'hBBBB);
    chk("full_rsp2_instr_valid", instr_rsp_valid_o, 0);
    chk("full_third_valid", mem_req_valid_o, 1);
    chk("full_third_ready", instr_req_ready_o, 1);
    chk("full_third_addr", mem_req_addr_o, 32'h600);
    cyc();
    instr_req_valid_i = 1'b0;
    mem_rsp_data_i = 32'hCCCC;
    #2;
    chk("full_rsp3_instr_valid", instr_rsp_valid_o, 1);
    chk("full_rsp3_instr_data", instr_rsp_data_o, 32'hCCCC);
    cyc();
    mem_rsp_valid_i = 1'b0;
    #2;
    chk("full_outst_end", outstanding_o, 0);

    // Error response held off by the data stage for two cycles.
    idle();
    mem_req_ready_i = 1'b1;
    data_req_valid_i = 1'b1; data_req_addr_i = 32'h700;
    #2;
    chk("err_req_ready", data_req_ready_o, 1);
    cyc();
    data_req_valid_i = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rsp_error_i = 1'b1; mem_rsp_data_i = 32'h55;
    instr_rsp_ready_i = 1'b1; data_rsp_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #2;
      chk($sformatf("err_stall_mem_ready%0d", k), mem_rsp_ready_o, 0);
      chk($sformatf("err_stall_data_valid%0d", k), data_rsp_valid_o, 1);
      chk($sformatf("err_stall_instr_valid%0d", k), instr_rsp_valid_o, 0);
      chk($sformatf("err_stall_outst%0d", k), outstanding_o, 1);
      cyc();
    end
    data_rsp_ready_i = 1'b1;
    #2;
    chk("err_mem_ready", mem_rsp_ready_o, 1);
    chk("err_data_error", data_rsp_error_o, 1);
    cyc();
    mem_rsp_valid_i = 1'b0; mem_rsp_error_i = 1'b0;
    #2;
    chk("err_outst_end", outstanding_o, 0);

    // Asynchronous reset with two transactions in flight.
    idle();
    mem_req_ready_i = 1'b1;
    instr_req_valid_i = 1'b1; instr_req_addr_i = 32'h800;
    cyc();
    instr_req_valid_i = 1'b0;
    data_req_valid_i = 1'b1; data_req_addr_i = 32'h900;
    cyc();
    data_req_valid_i = 1'b0;
    instr_req_valid_i = 1'b1; instr_req_addr_i = 32'hA00;
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h1234; instr_rsp_ready_i = 1'b1;
    #2;
    chk("arst_pre_outst", outstanding_o, 2);
    chk("arst_pre_rsp_valid", instr_rsp_valid_o, 1);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("arst_outst", outstanding_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_mem_req_valid", mem_req_valid_o, 0);
    chk("arst_mem_req_addr", mem_req_addr_o, 0);
    chk("arst_instr_ready", instr_req_ready_o, 0);
    chk("arst_instr_rsp_valid", instr_rsp_valid_o, 0);
    chk("arst_instr_rsp_data", instr_rsp_data_o, 0);
    chk("arst_mem_rsp_ready", mem_rsp_ready_o, 0);
    idle();
    cyc(); cyc();
    rst_ni = 1'b1;
    cyc();
    do_fetch(32'hB00, 32'h1111_2222, "post_rst");

    // Randomized traffic against a queue-based model of the grant order.
    idle();
    i_pend = 0; d_pend = 0;
    m_q.delete();
    m_lock = -1;
    m_starve = 0;
    cyc();
    for (int n = 0; n < 400; n++) begin
      if (!i_pend && ($urandom_range(0, 2) == 0)) begin
        i_pend = 1; i_addr = $urandom;
      end
      if (!d_pend && ($urandom_range(0, 1) == 0)) begin
        d_pend = 1; d_addr = $urandom; d_data = $urandom; d_write = 1'($urandom);
        d_size = 3'($urandom); d_strb = 4'($urandom);
      end
      m_rdy = ($urandom_range(0, 3) != 0);
      r_vld = ($urandom_range(0, 2) != 0);
      i_rdy = ($urandom_range(0, 3) != 0);
      d_rdy = ($urandom_range(0, 3) != 0);
      r_data = $urandom; r_err = 1'($urandom);
      instr_req_valid_i = i_pend; instr_req_addr_i = i_addr;
      data_req_valid_i = d_pend; data_req_addr_i = d_addr; data_req_write_i = d_write;
      data_req_size_i = d_size; data_req_data_i = d_data; data_req_strb_i = d_strb;
      mem_req_ready_i = m_rdy; mem_rsp_valid_i = r_vld; mem_rsp_data_i = r_data;
      mem_rsp_error_i = r_err; instr_rsp_ready_i = i_rdy; data_rsp_ready_i = d_rdy;
      #2;

      // Who should own the port this cycle (-1 none, 0 fetch, 1 data).
      if (m_lock >= 0) g = m_lock;
      else if (m_q.size() == MAX) g = -1;
      else if (i_pend && d_pend) g = (m_starve == LIM) ? 0 : 1;
      else if (d_pend) g = 1;
      else if (i_pend) g = 0;
      else g = -1;

      chk($sformatf("rnd%0d_req_valid", n), mem_req_valid_o, (g >= 0));
      chk($sformatf("rnd%0d_instr_ready", n), instr_req_ready_o, (g == 0) && m_rdy);
      chk($sformatf("rnd%0d_data_ready", n), data_req_ready_o, (g == 1) && m_rdy);
      chk($sformatf("rnd%0d_outst", n), outstanding_o, m_q.size());
      if (g == 1) begin
        chk($sformatf("rnd%0d_d_addr", n), mem_req_addr_o, d_addr);
        chk($sformatf("rnd%0d_d_write", n), mem_req_write_o, d_write);
        chk($sformatf("rnd%0d_d_size", n), mem_req_size_o, d_size);
        chk($sformatf("rnd%0d_d_strb", n), mem_req_strb_o, d_strb);
      end else if (g == 0) begin
        chk($sformatf("rnd%0d_i_addr", n), mem_req_addr_o, i_addr);
        chk($sformatf("rnd%0d_i_write", n), mem_req_write_o, 0);
        chk($sformatf("rnd%0d_i_strb", n), mem_req_strb_o, 4'hF);
      end

      if (m_q.size() > 0) begin
        dst = m_q[0];
        exp_rsp_rdy = dst ? d_rdy : i_rdy;
        chk($sformatf("rnd%0d_mem_rsp_ready", n), mem_rsp_ready_o, exp_rsp_rdy);
        chk($sformatf("rnd%0d_instr_rsp_valid", n), instr_rsp_valid_o, r_vld && (dst == 0));
        chk($sformatf("rnd%0d_data_rsp_valid", n), data_rsp_valid_o, r_vld && (dst == 1));
        if (dst == 0) begin
          chk($sformatf("rnd%0d_instr_rsp_data", n), instr_rsp_data_o, r_data);
          chk($sformatf("rnd%0d_instr_rsp_err", n), instr_rsp_error_o, r_err);
        end else begin
          chk($sformatf("rnd%0d_data_rsp_data", n), data_rsp_data_o, r_data);
          chk($sformatf("rnd%0d_data_rsp_err", n), data_rsp_error_o, r_err);
        end
      end else begin
        exp_rsp_rdy = 0;
        chk($sformatf("rnd%0d_idle_rsp_ready", n), mem_rsp_ready_o, 0);
        chk($sformatf("rnd%0d_idle_instr_valid", n), instr_rsp_valid_o, 0);
        chk($sformatf("rnd%0d_idle_data_valid", n), data_rsp_valid_o, 0);
      end

      req_fire = (g >= 0) && m_rdy;
      rsp_fire = (m_q.size() > 0) && r_vld && exp_rsp_rdy;
      if (rsp_fire) void'(m_q.pop_front());
      if (req_fire) m_q.push_back(g);
      if (!i_pend) m_starve = 0;
      else if (req_fire && g == 0) m_starve = 0;
      else if (req_fire && g == 1 && m_starve < LIM) m_starve++;
      if (req_fire) m_lock = -1;
      else if (g >= 0) m_lock = g;
      if (req_fire && g == 0) i_pend = 0;
      if (req_fire && g == 1) d_pend = 0;
      cyc();
    end
    idle();
    #2;
    chk("rnd_final_outst", outstanding_o, m_q.size());
    drain("rnd");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
